// File: rtl/mem_loader.sv
// mem_loader: streams a boot image into data and instruction memories, then
// enables the processor.
//
// Stream frame: Nd, Nd data words, Ni, Ni instruction words. Each word is
// written one cycle after it is accepted, starting at BASE_ADDR in each region.
//
// Ports
//   clk                 single clock, rising edge
//   rst_n               asynchronous active-low reset
//   load_req            one-cycle pulse starting a load (honoured in IDLE/RUN/ERR)
//   in_data/in_valid    input word stream
//   in_ready            word accepted when in_valid && in_ready
//   addr_ext            dram/iram write address
//   data_in_ext         dram write data
//   mem_write_data_ext  dram write strobe
//   iram_in_ext         iram write data
//   mem_write_ins       iram write strobe
//   start               processor run enable (RUN state)
//   busy                load in progress
//   error               count exceeded MAX_WORDS
module mem_loader #(
   parameter int unsigned MAX_WORDS = 511,
   parameter int unsigned BASE_ADDR = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_req,
   input  logic [15:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [15:0] addr_ext,
   output logic [15:0] data_in_ext,
   output logic        mem_write_data_ext,
   output logic [15:0] iram_in_ext,
   output logic        mem_write_ins,
   output logic        start,
   output logic        busy,
   output logic        error
);

   localparam logic [15:0] MaxWords = 16'(MAX_WORDS);
   localparam logic [15:0] BaseAddr = 16'(BASE_ADDR);

   typedef enum logic [3:0] {
      StIdle, StDCnt, StDWord, StDWr, StICnt, StIWord, StIWr, StRun, StErr
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] cnt_q;   // words still to write in the current region
   logic [15:0] addr_q;  // next write address; copied to addr_ext only with a strobe
   logic        accept;

   assign accept = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle, StRun, StErr: if (load_req) state_d = StDCnt;
         StDCnt: begin
            if (accept) begin
               if (in_data > MaxWords)  state_d = StErr;
               else if (in_data == '0)  state_d = StICnt;
               else                     state_d = StDWord;
            end
         end
         StDWord: if (accept) state_d = StDWr;
         StDWr:   state_d = (cnt_q == 16'd1) ? StICnt : StDWord;
         StICnt: begin
            if (accept) begin
               if (in_data > MaxWords)  state_d = StErr;
               else if (in_data == '0)  state_d = StRun;
               else                     state_d = StIWord;
            end
         end
         StIWord: if (accept) state_d = StIWr;
         StIWr:   state_d = (cnt_q == 16'd1) ? StRun : StIWord;
         default: state_d = StIdle;
      endcase
   end

   // All outputs are registered from the next state so they change with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q            <= StIdle;
         cnt_q              <= '0;
         addr_q             <= '0;
         in_ready           <= 1'b0;
         addr_ext           <= '0;
         data_in_ext        <= '0;
         mem_write_data_ext <= 1'b0;
         iram_in_ext        <= '0;
         mem_write_ins      <= 1'b0;
         start              <= 1'b0;
         busy               <= 1'b0;
         error              <= 1'b0;
      end else begin
         state_q            <= state_d;
         in_ready           <= state_d inside {StDCnt, StDWord, StICnt, StIWord};
         busy               <= !(state_d inside {StIdle, StRun, StErr});
         error              <= (state_d == StErr);
         start              <= (state_d == StRun);
         mem_write_data_ext <= (state_d == StDWr);
         mem_write_ins      <= (state_d == StIWr);
         case (state_q)
            StDCnt, StICnt: begin
               if (accept) begin
                  cnt_q  <= in_data;
                  addr_q <= BaseAddr;
               end
            end
            StDWord: begin
               if (accept) begin
                  data_in_ext <= in_data;
                  addr_ext    <= addr_q;
               end
            end
            StIWord: begin
               if (accept) begin
                  iram_in_ext <= in_data;
                  addr_ext    <= addr_q;
               end
            end
            StDWr, StIWr: begin
               addr_q <= addr_q + 16'd1;
               cnt_q  <= cnt_q - 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: stimulus pushes expected memory writes,
// a negedge monitor pops and compares on every write strobe.
module tb_mem_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load_req = 1'b0;
   logic [15:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] addr_ext, data_in_ext, iram_in_ext;
   logic        mem_write_data_ext, mem_write_ins, start, busy, error;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] dq[$];  // expected dram writes {addr, data}
   logic [31:0] iq[$];  // expected iram writes {addr, data}
   logic [15:0] dw[$];
   logic [15:0] iw[$];

   mem_loader #(.MAX_WORDS(511), .BASE_ADDR(1)) dut (
      .clk(clk), .rst_n(rst_n), .load_req(load_req), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .addr_ext(addr_ext),
      .data_in_ext(data_in_ext), .mem_write_data_ext(mem_write_data_ext),
      .iram_in_ext(iram_in_ext), .mem_write_ins(mem_write_ins), .start(start),
      .busy(busy), .error(error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every strobe must match the head of its scoreboard queue.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (mem_write_data_ext && mem_write_ins)
            chk("both_strobes", 2'b11, 2'b00);
         if (mem_write_data_ext) begin
            if (dq.size() == 0) chk("unexpected_dram_wr", {addr_ext, data_in_ext}, 64'hdead);
            else chk("dram_wr", {addr_ext, data_in_ext}, dq.pop_front());
         end
         if (mem_write_ins) begin
            if (iq.size() == 0) chk("unexpected_iram_wr", {addr_ext, iram_in_ext}, 64'hdead);
            else chk("iram_wr", {addr_ext, iram_in_ext}, iq.pop_front());
         end
      end
   end

   // Present one word; returns just before the posedge that accepts it.
   task automatic send_word(input logic [15:0] w, input bit gaps);
      int n = 0;
      bit done = 0;
      while (!done) begin
         @(negedge clk);
         if (gaps && ($urandom_range(0, 1) == 0)) in_valid = 1'b0;
         else begin
            in_valid = 1'b1;
            in_data  = w;
         end
         if (in_valid && in_ready) done = 1;
         n++;
         if (!done && n > 200) begin
            chk("send_timeout", 1, 0);
            done = 1;
         end
      end
   endtask

   task automatic pulse_load();
      @(negedge clk);
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
      chk("after_load_req", {start, busy, error}, 3'b010);
   endtask

   // Reference model: frame from dw/iw with counts nd/ni; expected writes and end state.
   task automatic run_frame(input int nd, input int ni, input bit gaps);
      bit err = 0;
      bit prev_ins = 0;
      int k;
      pulse_load();
      if (nd > 511) err = 1;
      else begin
         for (int i = 0; i < nd; i++) dq.push_back({16'(i + 1), dw[i]});
         if (ni > 511) err = 1;
         else for (int i = 0; i < ni; i++) iq.push_back({16'(i + 1), iw[i]});
      end
      send_word(16'(nd), gaps);
      if (nd <= 511) begin
         for (int i = 0; i < nd; i++) send_word(dw[i], gaps);
         send_word(16'(ni), gaps);
         if (ni <= 511) for (int i = 0; i < ni; i++) send_word(iw[i], gaps);
      end
      @(negedge clk);
      in_valid = 1'b0;
      for (k = 0; k < 100; k++) begin
         if (start || error) break;
         prev_ins = mem_write_ins;
         @(negedge clk);
      end
      if (k == 100) chk("end_timeout", 1, 0);
      chk("end_start_err_busy", {start, error, busy, in_ready}, {!err, err, 2'b00});
      if (!err && ni > 0) chk("start_after_last_ins", prev_ins, 1'b1);
      chk("queues_drained", 32'(dq.size() + iq.size()), 0);
      // idle a few cycles; monitor catches any stray write
      repeat (3) @(negedge clk);
      chk("end_hold", {start, error}, {!err, err});
   endtask

   task automatic fill_random(input int nd, input int ni);
      dw.delete();
      iw.delete();
      for (int i = 0; i < nd; i++) dw.push_back(16'($urandom));
      for (int i = 0; i < ni; i++) iw.push_back(16'($urandom));
   endtask

   initial begin
      #2;
      chk("reset_outputs",
          {addr_ext, data_in_ext, iram_in_ext, mem_write_data_ext, mem_write_ins,
           start, busy, error, in_ready}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_after_reset", {start, busy, error, in_ready}, 4'b0000);

      // Basic frame
      dw = '{16'd10, 16'd20, 16'd30};
      iw = '{16'h1234, 16'h5678};
      run_frame(3, 2, 0);

      // Empty data region
      dw.delete();
      iw = '{16'd7};
      run_frame(0, 1, 0);

      // Oversized data count, then recovery
      run_frame(512, 0, 0);
      fill_random(2, 2);
      run_frame(2, 2, 0);

      // Oversized instruction count
      fill_random(1, 0);
      run_frame(1, 512, 1);

      // Stalled stream
      fill_random(4, 1);
      run_frame(4, 1, 1);

      // Reset during the second instruction write
      pulse_load();
      dw = '{16'hbeef};
      dq.push_back({16'd1, 16'hbeef});
      iq.push_back({16'd1, 16'haaaa});
      send_word(16'd1, 0);
      send_word(16'hbeef, 0);
      send_word(16'd3, 0);
      send_word(16'haaaa, 0);
      send_word(16'hbbbb, 0);
      @(posedge clk);
      #1;
      chk("second_ins_strobe", {mem_write_ins, addr_ext}, {1'b1, 16'd2});
      rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("async_reset_clear",
          {addr_ext, data_in_ext, iram_in_ext, mem_write_data_ext, mem_write_ins,
           start, busy, error, in_ready}, 64'h0);
      dq.delete();
      iq.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("no_activity_after_reset", {start, busy, error, in_ready}, 4'b0000);
      fill_random(2, 3);
      run_frame(2, 3, 0);

      // Reload while running (previous frame left DUT in RUN)
      fill_random(3, 2);
      run_frame(3, 2, 1);

      // Maximum legal count
      fill_random(511, 0);
      run_frame(511, 0, 0);

      // Random frames
      for (int t = 0; t < 8; t++) begin
         int nd, ni;
         nd = $urandom_range(0, 6);
         ni = $urandom_range(0, 6);
         fill_random(nd, ni);
         run_frame(nd, ni, 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

endmodule
